// File: rtl/uart_mmio_responder.sv
// Memory-mapped 8N1 UART responder for the CPU I/O window: TX/RX engines,
// one-byte receive holding register, sticky error flags and a cycle counter.
module uart_mmio_responder #(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE      = 115200,
  parameter int CLKS_PER_BIT   = CPU_CLOCK_FREQ / BAUD_RATE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        serial_rx,
  output logic        serial_tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_TXDATA = 3'd2;
  localparam logic [2:0] REG_CYCLES = 3'd3;
  localparam logic [2:0] REG_CYCRST = 3'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus decode
  logic [2:0] w_sel;
  logic       w_any_we;
  logic       w_rd;
  logic       w_rd_status;
  logic       w_rd_rxdata;
  logic       w_tx_wr;
  logic       w_cyc_clr;
  logic       w_unused;

  assign w_sel       = addr[4:2];
  assign w_any_we    = |we;
  assign w_rd        = re & ~w_any_we;
  assign w_rd_status = w_rd && (w_sel == REG_STATUS);
  assign w_rd_rxdata = w_rd && (w_sel == REG_RXDATA);
  assign w_tx_wr     = we[0] && (w_sel == REG_TXDATA);
  assign w_cyc_clr   = w_any_we && (w_sel == REG_CYCRST);
  assign w_unused    = ^{addr[1:0], wdata[31:8]};

  // RX line synchronizer
  logic r_rx_sync1;
  logic r_rx_sync2;
  logic w_rx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
    end else begin
      r_rx_sync1 <= serial_rx;
      r_rx_sync2 <= r_rx_sync1;
    end
  end

  assign w_rx = r_rx_sync2;

  // TX engine
  tx_state_t        r_tx_state, w_tx_state_next;
  logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_next;
  logic [2:0]       r_tx_idx, w_tx_idx_next;
  logic [7:0]       r_tx_shift, w_tx_shift_next;
  logic             r_tx_out, w_tx_out_next;
  logic             w_tx_ready;

  assign w_tx_ready = (r_tx_state == TX_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_out   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_idx   <= w_tx_idx_next;
      r_tx_shift <= w_tx_shift_next;
      r_tx_out   <= w_tx_out_next;
    end
  end

  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt;
    w_tx_idx_next   = r_tx_idx;
    w_tx_shift_next = r_tx_shift;
    w_tx_out_next   = r_tx_out;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_out_next = 1'b1;
        if (w_tx_wr) begin
          w_tx_state_next = TX_START;
          w_tx_cnt_next   = '0;
          w_tx_shift_next = wdata[7:0];
          w_tx_out_next   = 1'b0;
        end
      end
      TX_START: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_state_next = TX_DATA;
          w_tx_cnt_next   = '0;
          w_tx_idx_next   = '0;
          w_tx_out_next   = r_tx_shift[0];
        end else begin
          w_tx_cnt_next = r_tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_next = '0;
          if (r_tx_idx == 3'd7) begin
            w_tx_state_next = TX_STOP;
            w_tx_out_next   = 1'b1;
          end else begin
            w_tx_idx_next   = r_tx_idx + 3'd1;
            w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
            w_tx_out_next   = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt_next = r_tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_state_next = TX_IDLE;
          w_tx_cnt_next   = '0;
        end else begin
          w_tx_cnt_next = r_tx_cnt + 1'b1;
        end
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  assign serial_tx = r_tx_out;

  // RX engine
  rx_state_t        r_rx_state, w_rx_state_next;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_next;
  logic [2:0]       r_rx_idx, w_rx_idx_next;
  logic [7:0]       r_rx_shift, w_rx_shift_next;
  logic             w_rx_done;
  logic             w_rx_ferr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_rx_idx   <= w_rx_idx_next;
      r_rx_shift <= w_rx_shift_next;
    end
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_cnt_next   = r_rx_cnt;
    w_rx_idx_next   = r_rx_idx;
    w_rx_shift_next = r_rx_shift;
    w_rx_done       = 1'b0;
    w_rx_ferr       = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!w_rx) begin
          w_rx_state_next = RX_START;
          w_rx_cnt_next   = '0;
        end
      end
      RX_START: begin
        // Re-check mid start bit so short low glitches are rejected.
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_next   = '0;
          w_rx_idx_next   = '0;
          w_rx_state_next = w_rx ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_next = r_rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_next   = '0;
          w_rx_shift_next = {w_rx, r_rx_shift[7:1]};
          if (r_rx_idx == 3'd7) begin
            w_rx_state_next = RX_STOP;
          end else begin
            w_rx_idx_next = r_rx_idx + 3'd1;
          end
        end else begin
          w_rx_cnt_next = r_rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_next   = '0;
          w_rx_state_next = RX_IDLE;
          w_rx_done       = w_rx;
          w_rx_ferr       = ~w_rx;
        end else begin
          w_rx_cnt_next = r_rx_cnt + 1'b1;
        end
      end
      default: w_rx_state_next = RX_IDLE;
    endcase
  end

  // Holding register and sticky flags
  logic [7:0] r_rx_byte;
  logic       r_rx_valid;
  logic       r_overrun;
  logic       r_frame_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_byte   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // A read in the completion cycle frees the holder for the new byte.
      if (w_rx_done && (!r_rx_valid || w_rd_rxdata)) begin
        r_rx_byte  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_rd_rxdata) begin
        r_rx_valid <= 1'b0;
      end

      if (w_rx_done && r_rx_valid && !w_rd_rxdata) begin
        r_overrun <= 1'b1;
      end else if (w_rd_status) begin
        r_overrun <= 1'b0;
      end

      if (w_rx_ferr) begin
        r_frame_err <= 1'b1;
      end else if (w_rd_status) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  // Cycle counter
  logic [31:0] r_cycles;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cycles <= '0;
    end else if (w_cyc_clr) begin
      r_cycles <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  // Read data
  logic [31:0] r_rdata, w_rdata_next;

  always_comb begin
    w_rdata_next = '0;
    if (w_rd) begin
      case (w_sel)
        REG_STATUS: w_rdata_next = {28'd0, r_frame_err, r_overrun, r_rx_valid, w_tx_ready};
        REG_RXDATA: w_rdata_next = {24'd0, r_rx_byte};
        REG_CYCLES: w_rdata_next = r_cycles;
        default:    w_rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rdata_next;
    end
  end

  assign rdata = r_rdata;

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Directed bench for uart_mmio_responder with CLKS_PER_BIT=8: register-map
// vector table plus hand-written TX, RX, overrun, error and reset sequences.
module tb_uart_mmio_responder;

  localparam int CPB = 8;

  logic        clk;
  logic        rst;
  logic [4:0]  addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        serial_rx;
  logic        serial_tx;

  int n_vec;
  int n_err;

  uart_mmio_responder #(
    .CPU_CLOCK_FREQ(8 * 115200),
    .BAUD_RATE     (115200),
    .CLKS_PER_BIT  (CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .re       (re),
    .we       (we),
    .wdata    (wdata),
    .rdata    (rdata),
    .serial_rx(serial_rx),
    .serial_tx(serial_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  addr;
    logic        re;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string n, input logic [4:0] a, input logic r,
                              input logic [3:0] w, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.name = n; v.addr = a; v.re = r; v.we = w; v.wdata = d; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle; returns rdata sampled 1 ns after the edge.
  task automatic bus(input logic [4:0] a, input logic r, input logic [3:0] w,
                     input logic [31:0] d, output logic [31:0] q);
    addr = a; re = r; we = w; wdata = d;
    @(posedge clk); #1;
    q = rdata;
    $display("bus addr=%02h re=%0d we=%h wdata=%08h -> rdata=%08h", a, r, w, d, q);
    addr = '0; re = 1'b0; we = '0; wdata = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Drive one 8N1 frame; optionally issue an RXDATA read during cycle rd_at.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int rd_at, output logic [31:0] q);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    q  = '0;
    for (int i = 0; i < 10 * CPB; i++) begin
      serial_rx = fr[i / CPB];
      if (i == rd_at) begin
        addr = 5'h04; re = 1'b1;
      end
      @(posedge clk); #1;
      if (i == rd_at) begin
        q = rdata; addr = '0; re = 1'b0;
      end
    end
    serial_rx = 1'b1;
    $display("rx frame byte=%02h stop=%0d", b, stop_bit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    logic [9:0]  fr;

    n_vec = 0; n_err = 0;
    rst = 1'b0; addr = '0; re = 1'b0; we = '0; wdata = '0; serial_rx = 1'b1;

    // Register-map vectors; counter values count edges since the last clear.
    add("cycrst_wr",    5'h10, 1'b0, 4'hF, 32'h0,   32'h0);
    add("idle1",        5'h00, 1'b0, 4'h0, 32'h0,   32'h0);
    add("idle2",        5'h00, 1'b0, 4'h0, 32'h0,   32'h0);
    add("idle3",        5'h00, 1'b0, 4'h0, 32'h0,   32'h0);
    add("idle4",        5'h00, 1'b0, 4'h0, 32'h0,   32'h0);
    add("idle5",        5'h00, 1'b0, 4'h0, 32'h0,   32'h0);
    add("cycles_5",     5'h0C, 1'b1, 4'h0, 32'h0,   32'd5);
    add("cycles_6",     5'h0C, 1'b1, 4'h0, 32'h0,   32'd6);
    add("unmapped_14",  5'h14, 1'b1, 4'h0, 32'h0,   32'h0);
    add("wo_txdata_rd", 5'h08, 1'b1, 4'h0, 32'h0,   32'h0);
    add("wo_cycrst_rd", 5'h10, 1'b1, 4'h0, 32'h0,   32'h0);
    add("re_we_cycrst", 5'h10, 1'b1, 4'hF, 32'h0,   32'h0);
    add("cycles_0",     5'h0C, 1'b1, 4'h0, 32'h0,   32'd0);
    add("status_idle",  5'h00, 1'b1, 4'h0, 32'h0,   32'h1);
    add("rxdata_rst",   5'h04, 1'b1, 4'h0, 32'h0,   32'h0);
    add("unmapped_1c",  5'h1C, 1'b1, 4'h0, 32'h0,   32'h0);
    add("cycles_4",     5'h0C, 1'b1, 4'h0, 32'h0,   32'd4);
    add("cycrst_we1",   5'h10, 1'b0, 4'h2, 32'h0,   32'h0);
    add("re0_cycles",   5'h0C, 1'b0, 4'h0, 32'h0,   32'h0);
    add("cycles_1",     5'h0C, 1'b1, 4'h0, 32'h0,   32'd1);
    add("tx_we0_clear", 5'h08, 1'b0, 4'hE, 32'hFF,  32'h0);
    add("status_no_tx", 5'h00, 1'b1, 4'h0, 32'h0,   32'h1);
    add("cycles_lowbit",5'h0F, 1'b1, 4'h0, 32'h0,   32'd4);
    add("status_lowbit",5'h02, 1'b1, 4'h0, 32'h0,   32'h1);

    // Reset held for three edges
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_serial_tx", {31'd0, serial_tx}, 32'd1);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b1;
    bus(5'h00, 1'b1, 4'h0, 32'h0, q); chk("rst_status", q, 32'h1);
    bus(5'h0C, 1'b1, 4'h0, 32'h0, q); chk("rst_cycles", q, 32'd1);

    foreach (tbl[i]) begin
      bus(tbl[i].addr, tbl[i].re, tbl[i].we, tbl[i].wdata, q);
      chk(tbl[i].name, q, tbl[i].exp);
    end

    // TX frame of 0xA5 accepted at edge N; sample k mirrors the line just before edge N+1+k.
    bus(5'h08, 1'b0, 4'h1, 32'h0000_00A5, q);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      chk($sformatf("tx_bit_k%0d", k), {31'd0, serial_tx}, {31'd0, fr[k / CPB]});
      if (k == 20) begin
        addr = 5'h08; we = 4'h1; wdata = 32'h0000_00FF;
      end
      if (k == 40 || k == 79) begin
        addr = 5'h00; re = 1'b1;
      end
      @(posedge clk); #1;
      if (k == 40 || k == 79) chk($sformatf("tx_busy_status_k%0d", k), rdata, 32'h0);
      addr = '0; re = 1'b0; we = '0; wdata = '0;
    end
    chk("tx_line_idle", {31'd0, serial_tx}, 32'd1);

    // Back-to-back: write at edge N+81 is accepted, then reset aborts the frame.
    bus(5'h08, 1'b0, 4'h1, 32'h0000_0000, q);
    chk("tx_b2b_start", {31'd0, serial_tx}, 32'd0);
    bus(5'h00, 1'b1, 4'h0, 32'h0, q); chk("tx_b2b_busy", q, 32'h0);
    idle(15);
    chk("tx_b2b_data0", {31'd0, serial_tx}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("tx_rst_abort", {31'd0, serial_tx}, 32'd1);
    rst = 1'b1;
    bus(5'h00, 1'b1, 4'h0, 32'h0, q); chk("tx_rst_status", q, 32'h1);

    // RX loopback of 0x3C
    send_frame(8'h3C, 1'b1, -1, q);
    bus(5'h00, 1'b1, 4'h0, 32'h0, q); chk("rx_status_valid", q, 32'h3);
    bus(5'h04, 1'b1, 4'h0, 32'h0, q); chk("rx_data_3c", q, 32'h3C);
    bus(5'h00, 1'b1, 4'h0, 32'h0, q); chk("rx_status_clr", q, 32'h1);

    // Overrun: second byte dropped, first kept
    send_frame(8'h11, 1'b1, -1, q);
    send_frame(8'h22, 1'b1, -1, q);
    bus(5'h00, 1'b1, 4'h0, 32'h0, q); chk("ovr_status", q, 32'h7);
    bus(5'h00, 1'b1, 4'h0, 32'h0, q); chk("ovr_status2", q, 32'h3);
    bus(5'h04, 1'b1, 4'h0, 32'h0, q); chk("ovr_data", q, 32'h11);
    bus(5'h00, 1'b1, 4'h0, 32'h0, q); chk("ovr_status3", q, 32'h1);

    // Two-cycle low glitch is rejected
    serial_rx = 1'b0;
    idle(2);
    serial_rx = 1'b1;
    idle(20);
    bus(5'h00, 1'b1, 4'h0, 32'h0, q); chk("glitch_status", q, 32'h1);

    // Bad stop bit
    send_frame(8'h55, 1'b0, -1, q);
    idle(12);
    bus(5'h00, 1'b1, 4'h0, 32'h0, q); chk("ferr_status", q, 32'h9);
    bus(5'h00, 1'b1, 4'h0, 32'h0, q); chk("ferr_status2", q, 32'h1);

    // RXDATA read in the stop-completion cycle: start seen 3 edges after the
    // line falls, mid-start check 4 later, 9 bits of 8 -> completes at cycle 78.
    send_frame(8'h5A, 1'b1, -1, q);
    send_frame(8'hC3, 1'b1, 78, q);
    chk("same_cyc_old", q, 32'h5A);
    bus(5'h00, 1'b1, 4'h0, 32'h0, q); chk("same_cyc_status", q, 32'h3);
    bus(5'h04, 1'b1, 4'h0, 32'h0, q); chk("same_cyc_new", q, 32'hC3);
    bus(5'h00, 1'b1, 4'h0, 32'h0, q); chk("same_cyc_status2", q, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
